decode_dispatch_buffer: RTL and testbench

Consumer-side counterpart of the decode pipeline register. Accepts the registered decoded-instruction bundle (opcode, group, specifier, funct3, funct7, rs1, rs2, rd, imm20) from the decode stage. Holds it in a small circular FIFO and hands it to the issue/execute stage over a valid/ready handshake. This decouples decode from execute stalls. A synchronous flush discards all buffered instructions on redirect.

---
 rtl/decode_pkg.sv | 36 +++
 rtl/dispatch_ptr_ctrl.sv | 43 ++++
 rtl/decode_dispatch_buffer.sv | 96 +++++++++
 tb/tb_decode_dispatch_buffer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decoded-instruction definitions.
// Used by the decode pipeline register, the dispatch buffer and the issue stage.
// Bundle layout, MSB first:
//   opcode, group, specifier, funct3, funct7, rs1, rs2, rd, imm20
package decode_pkg;
  localparam int OPCODE_W = 7;
  localparam int GROUP_W  = 2;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 21;
  localparam int BUNDLE_W = 56;

  // Field LSB offsets within the packed 56-bit bundle.
  localparam int IMM_LSB    = 0;
  localparam int RD_LSB     = IMM_LSB + IMM_W;       // 21
  localparam int RS2_LSB    = RD_LSB + REG_W;        // 26
  localparam int RS1_LSB    = RS2_LSB + REG_W;       // 31
  localparam int FUNCT7_LSB = RS1_LSB + REG_W;       // 36
  localparam int FUNCT3_LSB = FUNCT7_LSB + FUNCT7_W; // 43
  localparam int SPEC_LSB   = FUNCT3_LSB + FUNCT3_W; // 46
  localparam int GROUP_LSB  = SPEC_LSB + 1;          // 47
  localparam int OPCODE_LSB = GROUP_LSB + GROUP_W;   // 49

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [GROUP_W-1:0]  group;
    logic                specifier;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic [IMM_W-1:0]    imm20;
  } decoded_bundle_t;
endpackage

// File: rtl/dispatch_ptr_ctrl.sv
// Pointer/occupancy control for the decode dispatch FIFO.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   flush         synchronous discard; wins over push/pop
//   push, pop     qualified handshakes from the top level
//   wr_ptr/rd_ptr circular pointers (natural PTR_W wrap)
//   count         occupancy 0..DEPTH; full/empty decoded from it
module dispatch_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  // Pointers alone cannot tell full from empty; occupancy decides.
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/decode_dispatch_buffer.sv
// Decode-to-issue dispatch buffer: small circular FIFO of decoded bundles
// with valid/ready on both sides and a synchronous flush for redirects.
// Ports:
//   clk, rst_n, flush
//   in_valid/in_ready + in_* decoded fields   (from decode register)
//   out_valid/out_ready + out_* head fields   (to issue stage, zero when !out_valid)
//   count                                      occupancy 0..DEPTH
// Optional: DECODE_DISPATCH_BYPASS_EN adds a zero-latency in->out path
// when the buffer is empty.
module decode_dispatch_buffer
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [GROUP_W-1:0]  in_group,
  input  logic                in_specifier,
  input  logic [FUNCT3_W-1:0] in_funct3,
  input  logic [FUNCT7_W-1:0] in_funct7,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [IMM_W-1:0]    in_imm20,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [GROUP_W-1:0]  out_group,
  output logic                out_specifier,
  output logic [FUNCT3_W-1:0] out_funct3,
  output logic [FUNCT7_W-1:0] out_funct7,
  output logic [REG_W-1:0]    out_rs1,
  output logic [REG_W-1:0]    out_rs2,
  output logic [REG_W-1:0]    out_rd,
  output logic [IMM_W-1:0]    out_imm20,
  output logic [PTR_W:0]      count
);
  decoded_bundle_t       in_b;
  logic [BUNDLE_W-1:0]   mem [DEPTH];
  logic [BUNDLE_W-1:0]   out_raw, out_b;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  full, empty, byp, thru, push, pop;

  assign in_b = '{opcode: in_opcode, group: in_group, specifier: in_specifier,
                  funct3: in_funct3, funct7: in_funct7, rs1: in_rs1,
                  rs2: in_rs2, rd: in_rd, imm20: in_imm20};

`ifdef DECODE_DISPATCH_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif
  // Bundle consumed straight through: neither stored nor counted.
  assign thru = byp & out_ready;

  assign in_ready  = ~full;
  assign out_valid = ~empty | byp;
  assign push      = in_valid & in_ready & ~thru;
  assign pop       = ~empty & out_ready;

  dispatch_ptr_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Storage is deliberately unreset; masking below hides stale data.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_b;
  end

  assign out_raw = byp ? in_b : mem[rd_ptr];
  assign out_b   = out_valid ? out_raw : '0;

  assign out_opcode    = out_b[OPCODE_LSB +: OPCODE_W];
  assign out_group     = out_b[GROUP_LSB  +: GROUP_W];
  assign out_specifier = out_b[SPEC_LSB];
  assign out_funct3    = out_b[FUNCT3_LSB +: FUNCT3_W];
  assign out_funct7    = out_b[FUNCT7_LSB +: FUNCT7_W];
  assign out_rs1       = out_b[RS1_LSB    +: REG_W];
  assign out_rs2       = out_b[RS2_LSB    +: REG_W];
  assign out_rd        = out_b[RD_LSB     +: REG_W];
  assign out_imm20     = out_b[IMM_LSB    +: IMM_W];
endmodule

// File: tb/tb_decode_dispatch_buffer.sv
// Self-checking bench for decode_dispatch_buffer: directed scenarios then
// randomized traffic, all compared against a queue-based FIFO model.
module tb_decode_dispatch_buffer;
  localparam int DEPTH = 4;
`ifdef DECODE_DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready, in_ready, out_valid;
  logic [6:0] in_opcode, out_opcode;
  logic [1:0] in_group, out_group;
  logic       in_specifier, out_specifier;
  logic [2:0] in_funct3, out_funct3;
  logic [6:0] in_funct7, out_funct7;
  logic [4:0] in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [20:0] in_imm20, out_imm20;
  logic [2:0] count;
  logic [55:0] in_b, out_b;

  assign {in_opcode, in_group, in_specifier, in_funct3, in_funct7,
          in_rs1, in_rs2, in_rd, in_imm20} = in_b;
  assign out_b = {out_opcode, out_group, out_specifier, out_funct3, out_funct7,
                  out_rs1, out_rs2, out_rd, out_imm20};

  always #5 clk = ~clk;

  decode_dispatch_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_group(in_group), .in_specifier(in_specifier),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd), .in_imm20(in_imm20),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_group(out_group), .out_specifier(out_specifier),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_imm20(out_imm20),
    .count(count)
  );

  int n_chk = 0, n_pass = 0;
  logic [55:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [55:0] rnd_b(input logic [4:0] rd);
    logic [55:0] b;
    b = {$urandom, $urandom};
    b[25:21] = rd;
    return b;
  endfunction

  // Check outputs mid-cycle against the model, then advance the model by
  // the edge that is about to happen. Called right after a negedge.
  task automatic cyc(input string tag);
    bit bypass, ev, push, pop;
    logic [55:0] eo;
    #1;
    bypass = BYP && q.size() == 0 && in_valid && !flush;
    ev = (q.size() != 0) || bypass;
    eo = (q.size() != 0) ? q[0] : (bypass ? in_b : 56'h0);
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() != DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".count"},     64'(count),     64'(q.size()));
    chk({tag, ".out"},       64'(out_b),     64'(eo));
    if (flush) q.delete();
    else if (!(bypass && out_ready)) begin
      push = in_valid && (q.size() != DEPTH);
      pop  = (q.size() != 0) && out_ready;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(in_b);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; flush = 0; in_b = '0;
  endtask

  initial begin
    rst_n = 0; idle();
    @(negedge clk); #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.count",     64'(count),     64'd0);
    chk("rst.out",       64'(out_b),     64'd0);
    @(negedge clk); rst_n = 1;

    // 1: single push, hold with out_ready low
    in_valid = 1; in_b = '0;
    in_b[55:49] = 7'h33; in_b[25:21] = 5'd3; in_b[20:0] = 21'h1ABCD;
    cyc("t1.push");
    in_valid = 0;
    chk("t1.rd", 64'(out_rd), 64'd3);
    for (int i = 0; i < 3; i++) cyc("t1.hold");
    out_ready = 1; cyc("t1.pop"); out_ready = 0; cyc("t1.empty");

    // 2: overfill then drain in order
    for (int i = 1; i <= 5; i++) begin in_valid = 1; in_b = rnd_b(5'(i)); cyc("t2.fill"); end
    in_valid = 0;
    chk("t2.count", 64'(count), 64'd4);
    chk("t2.in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2.drain_rd", 64'(out_rd), 64'(i));
      cyc("t2.drain");
    end
    cyc("t2.empty"); out_ready = 0;

    // 3: streaming with both sides always ready
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_b = rnd_b(5'(i));
      cyc("t3.stream");
      if (!BYP) chk("t3.rd", 64'(out_rd), 64'(i));
    end
    idle(); out_ready = 1; cyc("t3.tail"); idle(); cyc("t3.done");

    // 4: flush with a concurrent push
    for (int i = 0; i < 3; i++) begin in_valid = 1; in_b = rnd_b(5'(i + 7)); cyc("t4.fill"); end
    flush = 1; in_b = rnd_b(5'd20); cyc("t4.flush");
    idle();
    chk("t4.count", 64'(count), 64'd0);
    chk("t4.out_valid", 64'(out_valid), 64'd0);
    cyc("t4.after");

    // 5: asynchronous reset mid-cycle
    for (int i = 0; i < 2; i++) begin in_valid = 1; in_b = rnd_b(5'(i)); cyc("t5.fill"); end
    idle();
    #3 rst_n = 0; #1;
    chk("t5.count", 64'(count), 64'd0);
    chk("t5.out_valid", 64'(out_valid), 64'd0);
    chk("t5.out", 64'(out_b), 64'd0);
    q.delete();
    @(negedge clk); rst_n = 1;

    // 6: empty buffer, offer with out_ready high
    in_valid = 1; out_ready = 1; in_b = rnd_b(5'd1); in_b[35:31] = 5'd9;
    #1;
    chk("t6.out_valid", 64'(out_valid), 64'(BYP));
    chk("t6.rs1", 64'(out_rs1), BYP ? 64'd9 : 64'd0);
    #1;
    cyc("t6");
    idle(); cyc("t6.after");
    chk("t6.count", 64'(count), BYP ? 64'd0 : 64'd1);
    out_ready = 1; cyc("t6.drain"); idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 19) == 0);
      in_b      = {$urandom, $urandom};
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
